ps2_kbd_ascii: RTL and testbench
================================

PS2_KBD_ASCII -- requirements
Module: ps2_kbd_ascii

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_HZ, 1000000, system clock frequency; used to size the frame timeout.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges within a frame, in microseconds.
- FIFO_DEPTH, 4, number of ASCII entries in the output FIFO; power of two, 2..16.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- ps2_clk, in, 1, PS/2 device clock; asynchronous to clk.
- ps2_data, in, 1, PS/2 device data; asynchronous to clk.
- kbd_rdy, out, 1, key available for the consumer.
- kbd_ack, in, 1, consumer acknowledge (four-phase handshake).
- kbd_data, out, 7, ASCII code of the key; valid while kbd_rdy=1.
- rx_err, out, 1, one-cycle pulse on a frame error or timeout.
- ovf, out, 1, one-cycle pulse when a decoded key is dropped because the FIFO is full.

Function
REQ-003 ps2_clk and ps2_data each pass through a 2-flop synchronizer; a falling edge is detected on the synchronized clock (sync_prev=1, sync_now=0).

REQ-004 Receiver frame format, one bit sampled per falling edge:
- start bit = 0;
- 8 data bits, LSB first;
- odd parity bit;
- stop bit = 1.

REQ-005 Receiver state machine: IDLE -> DATA (8 bits) -> PARITY -> STOP -> IDLE.
- IDLE stays in IDLE if the sampled start bit is 1.

REQ-006 Frame errors: on a parity error or stop bit = 0, the byte is discarded, rx_err pulses for 1 cycle, and the receiver returns to IDLE.

REQ-007 Frame timeout:
- Outside IDLE, a counter increments every clk and clears on each falling edge.
- Reaching CLK_HZ*TIMEOUT_US/1000000 forces IDLE and pulses rx_err.

REQ-008 Decoder (PS/2 scan set 2):
- 0xF0 sets the break flag; the next code is consumed and clears the flag.
- 0xE0 sets the extended flag; the next code (including a following F0-pair) is consumed and ignored.

REQ-009 Shift tracking:
- Make codes 0x12 and 0x59 set the shift bit.
- Their break codes clear it.
- Shift keys emit no ASCII.

REQ-010 ASCII mapping for make codes; letters always map to uppercase:
- A-Z map to 0x41-0x5A.
- Digits 0-9 map to 0x30-0x39 unshifted.
- Shifted digits 1-9,0 map to !"#$%&'() as 0x21-0x29.
- Space 0x29 maps to 0x20; Enter 0x5A maps to 0x0D; Esc 0x76 maps to 0x1B.
- Backspace 0x66 maps to 0x5F; comma 0x41 maps to 0x2C; period 0x49 maps to 0x2E; minus 0x4E maps to 0x2D; slash 0x4A maps to 0x2F.
- Unlisted codes are ignored.

REQ-011 Each mapped make code is written to the FIFO one cycle after the stop bit is accepted.
- If the FIFO is full, the key is dropped and ovf pulses for 1 cycle.

REQ-012 Output handshake FSM, states H_IDLE -> H_RDY -> H_WAIT:
- H_IDLE: when the FIFO is non-empty, pop the head into the kbd_data register, set kbd_rdy=1, go to H_RDY.
- H_RDY: on kbd_ack=1, clear kbd_rdy, go to H_WAIT.
- H_WAIT: on kbd_ack=0, go to H_IDLE.

REQ-013 kbd_data holds its last value until the next pop; it is never changed while kbd_rdy=1.

REQ-014 Minimum latency from the accepting stop-bit edge to kbd_rdy=1 is 3 clk when the FIFO is empty and the FSM is in H_IDLE.

REQ-015 Simultaneous FIFO push and pop in the same cycle are both performed; count is unchanged; there is no overflow when the FIFO was full.

REQ-016 The receiver runs independently of the handshake; a stalled consumer never blocks frame reception.

Reset
REQ-017 While reset=1, the following hold:
- kbd_rdy=0, kbd_data=0, rx_err=0, ovf=0;
- FIFO empty;
- break, extended and shift flags cleared;
- receiver in IDLE, handshake FSM in H_IDLE;
- synchronizers preset to 1.

REQ-018 Reset asserted mid-frame or mid-handshake aborts the operation; the partial frame and any pending key are lost.

REQ-019 After reset release, a kbd_ack still high is ignored until it has been seen low once.

Verification
REQ-020 Frame 0x1C with correct parity -> kbd_data=0x41, kbd_rdy=1 within 3 clk; ack=1 -> rdy=0; ack=0 -> FSM returns to H_IDLE.

REQ-021 Sequence 0x1C, F0, 1C -> exactly one key 0x41; sequence 12, 16, F0 12, 16 -> keys 0x21 then 0x31.

REQ-022 Frame 0x1C with even parity -> rx_err pulses once, no kbd_rdy; next valid frame 0x29 -> 0x20.

REQ-023 kbd_ack held low, 6 keys sent with FIFO_DEPTH=4 -> first key in the output register, 4 keys in the FIFO, 1 ovf pulse; all 5 retained keys delivered in order.

REQ-024 ps2_clk stops after 4 bits -> rx_err after the timeout; next full frame 0x5A -> 0x0D.

REQ-025 Reset pulsed while kbd_rdy=1 -> kbd_rdy=0 immediately (asynchronous), FIFO empty, no stale key after release.

Source files
------------

// File: rtl/ps2_kbd_ascii.sv
// ps2_kbd_ascii: PS/2 keyboard receiver (scan set 2) with ASCII decode,
// output FIFO and a four-phase consumer handshake.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   ps2_clk   in   PS/2 device clock (asynchronous)
//   ps2_data  in   PS/2 device data (asynchronous)
//   kbd_rdy   out  key available for the consumer
//   kbd_ack   in   consumer acknowledge (four-phase)
//   kbd_data  out  7-bit ASCII code, valid while kbd_rdy=1
//   rx_err    out  one-cycle pulse on frame error or frame timeout
//   ovf       out  one-cycle pulse when a key is dropped on a full FIFO
//
// Receiver FSM
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (0) on a PS/2 falling edge
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | sampling the odd-parity bit
//   RX_STOP   | sampling the stop bit; good frame -> byte valid
//
// Handshake FSM
//   state     | meaning
//   H_IDLE    | output register free; pops the FIFO head when available
//   H_RDY     | kbd_rdy=1, waiting for kbd_ack=1
//   H_WAIT    | waiting for kbd_ack to return to 0

module ps2_kbd_ascii #(
  parameter int unsigned CLK_HZ     = 1000000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kbd_rdy,
  input  logic       kbd_ack,
  output logic [6:0] kbd_data,
  output logic       rx_err,
  output logic       ovf
);

  // 64-bit product so realistic clock rates do not overflow.
  localparam logic [63:0] TO_CYC_W = (64'(CLK_HZ) * 64'(TIMEOUT_US)) / 64'd1000000;
  localparam int unsigned TO_CYC   = (TO_CYC_W == 64'd0) ? 32'd1 : 32'(TO_CYC_W);
  localparam int          TO_W     = $clog2(TO_CYC + 1);
  localparam int          AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {H_IDLE, H_RDY, H_WAIT} hs_state_e;

  // ---------------- synchronizers and edge detect ----------------
  logic [1:0] ps2c_sync_q, ps2d_sync_q;
  logic       ps2c_prev_q;
  logic       fall, bit_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      ps2c_prev_q <= 1'b1;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
      ps2c_prev_q <= ps2c_sync_q[1];
    end
  end

  assign fall   = ps2c_prev_q & ~ps2c_sync_q[1];
  assign bit_in = ps2d_sync_q[1];

  // ---------------- receiver ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic            par_ok_q, par_ok_d;
  logic            byte_vld_q, byte_vld_d;
  logic            rx_err_q, rx_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      par_ok_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      rx_err_q   <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      par_ok_q   <= par_ok_d;
      byte_vld_q <= byte_vld_d;
      rx_err_q   <= rx_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    par_ok_d   = par_ok_q;
    byte_vld_d = 1'b0;
    rx_err_d   = 1'b0;
    to_cnt_d   = '0;

    // Gap timer: a falling edge and a timeout are mutually exclusive.
    if (rx_state_q != RX_IDLE && !fall) begin
      if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
        rx_state_d = RX_IDLE;
        rx_err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    if (fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!bit_in) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end
        end
        RX_DATA: begin
          rx_sr_d   = {bit_in, rx_sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d   = ^{rx_sr_q, bit_in};
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          if (bit_in && par_ok_q) byte_vld_d = 1'b1;
          else                    rx_err_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // ---------------- decoder ----------------
  // Returns {mapped, ascii}. Shift only changes the digit row.
  function automatic logic [7:0] map_code(input logic [7:0] code, input logic shifted);
    logic [7:0] r;
    logic [6:0] dig;
    logic       is_dig;
    r      = 8'h00;
    dig    = 7'd0;
    is_dig = 1'b0;
    case (code)
      8'h1C: r = {1'b1, 7'h41};  8'h32: r = {1'b1, 7'h42};
      8'h21: r = {1'b1, 7'h43};  8'h23: r = {1'b1, 7'h44};
      8'h24: r = {1'b1, 7'h45};  8'h2B: r = {1'b1, 7'h46};
      8'h34: r = {1'b1, 7'h47};  8'h33: r = {1'b1, 7'h48};
      8'h43: r = {1'b1, 7'h49};  8'h3B: r = {1'b1, 7'h4A};
      8'h42: r = {1'b1, 7'h4B};  8'h4B: r = {1'b1, 7'h4C};
      8'h3A: r = {1'b1, 7'h4D};  8'h31: r = {1'b1, 7'h4E};
      8'h44: r = {1'b1, 7'h4F};  8'h4D: r = {1'b1, 7'h50};
      8'h15: r = {1'b1, 7'h51};  8'h2D: r = {1'b1, 7'h52};
      8'h1B: r = {1'b1, 7'h53};  8'h2C: r = {1'b1, 7'h54};
      8'h3C: r = {1'b1, 7'h55};  8'h2A: r = {1'b1, 7'h56};
      8'h1D: r = {1'b1, 7'h57};  8'h22: r = {1'b1, 7'h58};
      8'h35: r = {1'b1, 7'h59};  8'h1A: r = {1'b1, 7'h5A};
      8'h45: begin is_dig = 1'b1; dig = 7'd0; end
      8'h16: begin is_dig = 1'b1; dig = 7'd1; end
      8'h1E: begin is_dig = 1'b1; dig = 7'd2; end
      8'h26: begin is_dig = 1'b1; dig = 7'd3; end
      8'h25: begin is_dig = 1'b1; dig = 7'd4; end
      8'h2E: begin is_dig = 1'b1; dig = 7'd5; end
      8'h36: begin is_dig = 1'b1; dig = 7'd6; end
      8'h3D: begin is_dig = 1'b1; dig = 7'd7; end
      8'h3E: begin is_dig = 1'b1; dig = 7'd8; end
      8'h46: begin is_dig = 1'b1; dig = 7'd9; end
      8'h29: r = {1'b1, 7'h20};  8'h5A: r = {1'b1, 7'h0D};
      8'h76: r = {1'b1, 7'h1B};  8'h66: r = {1'b1, 7'h5F};
      8'h41: r = {1'b1, 7'h2C};  8'h49: r = {1'b1, 7'h2E};
      8'h4E: r = {1'b1, 7'h2D};  8'h4A: r = {1'b1, 7'h2F};
      default: r = 8'h00;
    endcase
    // The shifted row only spans 0x21-0x29, so shifted 0 shares ')' with 9.
    if (is_dig) begin
      if (!shifted)          r = {1'b1, 7'h30 + dig};
      else if (dig == 7'd0)  r = {1'b1, 7'h29};
      else                   r = {1'b1, 7'h20 + dig};
    end
    return r;
  endfunction

  logic       brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
  logic       push_req;
  logic [7:0] mapped;
  logic       is_shift_key;

  assign mapped       = map_code(rx_sr_q, shift_q);
  assign is_shift_key = (rx_sr_q == 8'h12) || (rx_sr_q == 8'h59);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    if (byte_vld_q) begin
      if (rx_sr_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_sr_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (is_shift_key) shift_d = 1'b0;
      end else if (is_shift_key) begin
        shift_d = 1'b1;
      end else begin
        push_req = mapped[7];
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [6:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, fifo_empty, pop, do_push, ovf_q;

  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= mapped[6:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
      ovf_q <= push_req && !do_push;
    end
  end

  // ---------------- handshake ----------------
  hs_state_e  hs_state_q, hs_state_d;
  logic       rdy_q, rdy_d;
  logic [6:0] data_q, data_d;
  logic       ack_armed_q;

  // An ack left high across reset must go low once before it counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_state_q  <= H_IDLE;
      rdy_q       <= 1'b0;
      data_q      <= '0;
      ack_armed_q <= 1'b0;
    end else begin
      hs_state_q  <= hs_state_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
      if (!kbd_ack) ack_armed_q <= 1'b1;
    end
  end

  always_comb begin
    hs_state_d = hs_state_q;
    rdy_d      = rdy_q;
    data_d     = data_q;
    pop        = 1'b0;
    case (hs_state_q)
      H_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          data_d     = mem_q[rd_ptr_q];
          rdy_d      = 1'b1;
          hs_state_d = H_RDY;
        end
      end
      H_RDY: begin
        if (kbd_ack && ack_armed_q) begin
          rdy_d      = 1'b0;
          hs_state_d = H_WAIT;
        end
      end
      H_WAIT: begin
        if (!kbd_ack) hs_state_d = H_IDLE;
      end
      default: hs_state_d = H_IDLE;
    endcase
  end

  assign kbd_rdy  = rdy_q;
  assign kbd_data = data_q;
  assign rx_err   = rx_err_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
module tb_ps2_kbd_ascii;

  localparam int TO_CYC = 200;  // CLK_HZ=1MHz, TIMEOUT_US=200

  logic       clk, reset, ps2_clk, ps2_data, kbd_ack;
  logic       kbd_rdy, rx_err, ovf;
  logic [6:0] kbd_data;

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_ovf  = 0;

  ps2_kbd_ascii #(.CLK_HZ(1000000), .TIMEOUT_US(200), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_rdy(kbd_rdy), .kbd_ack(kbd_ack), .kbd_data(kbd_data),
    .rx_err(rx_err), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_sc [10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] spec_sc [9]    = '{8'h29,8'h5A,8'h76,8'h66,8'h41,8'h49,8'h4E,8'h4A,8'h41};
  int         spec_asc [9]   = '{'h20,'h0D,'h1B,'h5F,'h2C,'h2E,'h2D,'h2F,'h2C};

  bit m_brk, m_ext, m_shift;

  function automatic int ascii_of(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == c) return 'h41 + i;
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) return sh ? ((i == 0) ? 'h29 : 'h20 + i) : 'h30 + i;
    for (int i = 0; i < 9; i++) if (spec_sc[i] == c) return spec_asc[i];
    return -1;
  endfunction

  function automatic int model_key(input logic [7:0] c);
    bit is_sh;
    is_sh = (c == 8'h12) || (c == 8'h59);
    if (c == 8'hF0)      m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else if (m_ext)      begin m_ext = 1'b0; m_brk = 1'b0; end
    else if (m_brk)      begin m_brk = 1'b0; if (is_sh) m_shift = 1'b0; end
    else if (is_sh)      m_shift = 1'b1;
    else                 return ascii_of(c, m_shift);
    return -1;
  endfunction

  // ---------------- monitors ----------------
  logic       prev_rdy = 1'b0;
  logic [6:0] prev_data = '0;
  always @(negedge clk) begin
    if (rx_err === 1'b1) n_err++;
    if (ovf === 1'b1)    n_ovf++;
    if (!reset && kbd_rdy === 1'b1 && prev_rdy === 1'b1) begin
      checks++;
      if (kbd_data !== prev_data) begin
        errors++;
        $display("FAIL data_hold: kbd_data changed %0h -> %0h while kbd_rdy=1", prev_data, kbd_data);
      end
    end
    prev_rdy  = kbd_rdy;
    prev_data = kbd_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [10:0] bits, input int nbits, output int lat);
    logic rdy0;
    lat = 99;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (3) @(negedge clk);
      rdy0 = kbd_rdy;
      ps2_clk = 1'b0;
      for (int j = 1; j <= 6; j++) begin
        @(negedge clk);
        if (i == nbits - 1 && lat == 99 && !rdy0 && kbd_rdy) lat = j;
      end
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, output int lat);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    send_bits({1'b1, p, b, 1'b0}, 11, lat);
  endtask

  task automatic take_key(output logic [6:0] k, output bit got, output bit acked);
    got = 1'b0; acked = 1'b0; k = '0;
    for (int i = 0; i < 40; i++) begin
      if (kbd_rdy === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) begin
      k = kbd_data;
      kbd_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (kbd_rdy === 1'b0) begin acked = 1'b1; break; end
      end
      kbd_ack = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic watch_rdy(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kbd_rdy !== 1'b0) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; kbd_ack = 1'b0;
    m_brk = 0; m_ext = 0; m_shift = 0;
    repeat (4) @(negedge clk);
    checks++; if (kbd_rdy !== 1'b0)   begin errors++; $display("FAIL reset_rdy: got %b want 0", kbd_rdy); end
    checks++; if (kbd_data !== 7'h00) begin errors++; $display("FAIL reset_data: got %0h want 0", kbd_data); end
    checks++; if (rx_err !== 1'b0)    begin errors++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    reset = 1'b0;
    watch_rdy(10, seen);
    checks++; if (seen) begin errors++; $display("FAIL reset_idle: kbd_rdy rose after reset, want 0"); end
  endtask

  task automatic test_single();
    int lat; logic [6:0] k; bit got, acked; int exp;
    exp = model_key(8'h1C);
    send_byte(8'h1C, 1'b0, lat);
    checks++; if (lat > 5) begin errors++; $display("FAIL single_latency: got %0d clk from pin edge want <=5", lat); end
    checks++; if (kbd_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", kbd_rdy); end
    take_key(k, got, acked);
    checks++; if (!got || k !== 7'(exp)) begin errors++; $display("FAIL single_data: got %0h want %0h", k, exp); end
    checks++; if (!acked) begin errors++; $display("FAIL single_ack: kbd_rdy did not drop on ack"); end
  endtask

  task automatic test_sequences();
    logic [7:0] seq [8] = '{8'h1C, 8'hF0, 8'h1C, 8'h12, 8'h16, 8'hF0, 8'h12, 8'h16};
    int q [$]; int lat; logic [6:0] k; bit got, acked, seen; int r;
    for (int i = 0; i < 8; i++) begin
      r = model_key(seq[i]);
      if (r >= 0) q.push_back(r);
      send_byte(seq[i], 1'b0, lat);
    end
    foreach (q[i]) begin
      take_key(k, got, acked);
      checks++;
      if (!got || k !== 7'(q[i])) begin errors++; $display("FAIL seq_key%0d: got %0h (rdy=%b) want %0h", i, k, got, q[i]); end
    end
    watch_rdy(20, seen);
    checks++; if (seen) begin errors++; $display("FAIL seq_extra: extra key present, want none"); end
  endtask

  task automatic test_parity_err();
    int e0, lat, exp; logic [6:0] k; bit got, acked, seen;
    e0 = n_err;
    send_byte(8'h1C, 1'b1, lat);
    watch_rdy(15, seen);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL parity_rx_err: got %0d pulses want 1", n_err - e0); end
    checks++; if (seen) begin errors++; $display("FAIL parity_no_key: kbd_rdy rose, want 0"); end
    exp = model_key(8'h29);
    send_byte(8'h29, 1'b0, lat);
    take_key(k, got, acked);
    checks++; if (!got || k !== 7'(exp)) begin errors++; $display("FAIL parity_next: got %0h want %0h", k, exp); end
  endtask

  task automatic test_overflow();
    int q [$]; int o0, lat, r; logic [7:0] c; logic [6:0] k; bit got, acked, seen;
    o0 = n_ovf;
    kbd_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = letter_sc[$urandom_range(0, 25)];
      r = model_key(c);
      if (r >= 0) q.push_back(r);
      send_byte(c, 1'b0, lat);
    end
    checks++; if (n_ovf - o0 != 1) begin errors++; $display("FAIL ovf_pulse: got %0d pulses want 1", n_ovf - o0); end
    checks++; if (kbd_rdy !== 1'b1 || kbd_data !== 7'(q[0])) begin
      errors++; $display("FAIL ovf_head: got rdy=%b data=%0h want rdy=1 data=%0h", kbd_rdy, kbd_data, q[0]); end
    for (int i = 0; i < 5; i++) begin
      take_key(k, got, acked);
      checks++;
      if (!got || k !== 7'(q[i])) begin errors++; $display("FAIL ovf_key%0d: got %0h want %0h", i, k, q[i]); end
    end
    watch_rdy(20, seen);
    checks++; if (seen) begin errors++; $display("FAIL ovf_extra: dropped key delivered, want none"); end
  endtask

  task automatic test_timeout();
    int e0, lat, exp; logic [6:0] k; bit got, acked;
    e0 = n_err;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, lat);
    repeat (TO_CYC - 30) @(negedge clk);
    checks++; if (n_err != e0) begin errors++; $display("FAIL timeout_early: got %0d pulses want 0", n_err - e0); end
    repeat (60) @(negedge clk);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL timeout_err: got %0d pulses want 1", n_err - e0); end
    exp = model_key(8'h5A);
    send_byte(8'h5A, 1'b0, lat);
    take_key(k, got, acked);
    checks++; if (!got || k !== 7'(exp)) begin errors++; $display("FAIL timeout_next: got %0h want %0h", k, exp); end
  endtask

  task automatic test_reset_mid();
    int lat, r, exp; logic [6:0] k; bit got, acked, seen;
    kbd_ack = 1'b0;
    r = model_key(8'h12); send_byte(8'h12, 1'b0, lat);
    r = model_key(8'h1C); send_byte(8'h1C, 1'b0, lat);
    r = model_key(8'h1C); send_byte(8'h1C, 1'b0, lat);
    checks++; if (kbd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got rdy=%b want 1", kbd_rdy); end
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, lat);
    @(posedge clk); #3;
    reset = 1'b1; kbd_ack = 1'b1;
    #1;
    checks++; if (kbd_rdy !== 1'b0 || kbd_data !== 7'h00) begin
      errors++; $display("FAIL rstmid_async: got rdy=%b data=%0h want 0/0", kbd_rdy, kbd_data); end
    m_brk = 0; m_ext = 0; m_shift = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    watch_rdy(30, seen);
    checks++; if (seen) begin errors++; $display("FAIL rstmid_stale: stale key after reset, want none"); end
    exp = model_key(8'h16);
    send_byte(8'h16, 1'b0, lat);
    watch_rdy(1, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_key: got rdy=0 want 1"); end
    repeat (10) @(negedge clk);
    checks++; if (kbd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_ack_ignored: got rdy=%b want 1", kbd_rdy); end
    kbd_ack = 1'b0;
    @(negedge clk);
    take_key(k, got, acked);
    checks++; if (!got || k !== 7'(exp)) begin errors++; $display("FAIL rstmid_data: got %0h want %0h", k, exp); end
    checks++; if (!acked) begin errors++; $display("FAIL rstmid_handshake: rdy did not drop on armed ack"); end
  endtask

  task automatic test_random();
    int lat, r, e0, cat; logic [7:0] c; bit bad, got, acked, seen; logic [6:0] k;
    for (int n = 0; n < 60; n++) begin
      cat = $urandom_range(0, 9);
      case (cat)
        0, 1, 2: c = letter_sc[$urandom_range(0, 25)];
        3, 4:    c = digit_sc[$urandom_range(0, 9)];
        5:       c = spec_sc[$urandom_range(0, 8)];
        6:       c = 8'hF0;
        7:       c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        8:       c = 8'hE0;
        default: c = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 14) == 0);
      e0 = n_err;
      r = bad ? -1 : model_key(c);
      send_byte(c, bad, lat);
      if (bad) begin
        checks++;
        if (n_err - e0 != 1) begin errors++; $display("FAIL rand_err%0d: got %0d pulses want 1", n, n_err - e0); end
      end
      if (r >= 0) begin
        take_key(k, got, acked);
        checks++;
        if (!got || k !== 7'(r)) begin errors++; $display("FAIL rand_key%0d: code %0h got %0h want %0h", n, c, k, r); end
      end else begin
        watch_rdy(8, seen);
        checks++;
        if (seen) begin errors++; $display("FAIL rand_nokey%0d: code %0h produced a key, want none", n, c); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequences();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
